filter_ctrl_fsm: RTL and testbench

- Parametrised second-generation filter pump controller: fill pump A, then drain pump B at MIN duty, then at MAX duty, driven by the criticality of `status_data`.
- Added over the first generation: parametrised widths, timings and duty levels; slew-limited PWM ramping; enable gating; a drain-timeout watchdog; a refill limit; and a latched FAULT state with explicit clear.
- Sits between the sensor/level logic and the two PWM generators.

---
 rtl/filter_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_filter_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_ctrl_fsm.sv
// Filter pump controller: fills with pump A, then drains with pump B at a low
// and then a high duty, with slew-limited duty ramping, a drain watchdog, a
// refill limit and a latched FAULT state that needs an explicit clear.
module filter_ctrl_fsm #(
  parameter int              STATUS_W             = 4,
  parameter int              PWM_W                = 8,
  parameter int              PWM_MAX              = 230,
  parameter int              PWM_MIN              = 77,
  parameter longint unsigned FILL_CYCLES          = 64'd6_000_000_000,
  parameter longint unsigned MIN_CYCLES           = 64'd250_000_000,
  parameter longint unsigned DRAIN_TIMEOUT_CYCLES = 64'd1_500_000_000,
  parameter int              MAX_REFILLS          = 3,
  parameter int              RAMP_STEP            = 8,
  parameter int              RAMP_DIV             = 50_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [STATUS_W-1:0]                status_data,
  input  logic                               is_empty,
  input  logic                               fault_clear,
  output logic [PWM_W-1:0]                   pwm_duty_a,
  output logic [PWM_W-1:0]                   pwm_duty_b,
  output logic [2:0]                         state_o,
  output logic                               fault,
  output logic [$clog2(MAX_REFILLS+1)-1:0]   refill_count
);

  localparam int RCW = $clog2(MAX_REFILLS + 1);
  localparam int FTW = $clog2(FILL_CYCLES + 1);
  localparam int MTW = $clog2(MIN_CYCLES + 1);
  localparam int WTW = $clog2(DRAIN_TIMEOUT_CYCLES + 1);
  localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  // "LAST" values: the timer holds this during the final cycle of a dwell.
  localparam logic [FTW-1:0]   FILL_LAST = FTW'(FILL_CYCLES - 1);
  localparam logic [FTW-1:0]   FILL_TOP  = FTW'(FILL_CYCLES);
  localparam logic [MTW-1:0]   MIN_LAST  = MTW'(MIN_CYCLES - 1);
  localparam logic [MTW-1:0]   MIN_TOP   = MTW'(MIN_CYCLES);
  localparam logic [WTW-1:0]   WD_LAST   = WTW'(DRAIN_TIMEOUT_CYCLES - 1);
  localparam logic [WTW-1:0]   WD_TOP    = WTW'(DRAIN_TIMEOUT_CYCLES);
  localparam logic [RDW-1:0]   DIV_LAST  = RDW'(RAMP_DIV - 1);
  localparam logic [RCW-1:0]   REF_LIMIT = RCW'(MAX_REFILLS);
  localparam logic [PWM_W-1:0] DUTY_HI   = PWM_W'(PWM_MAX);
  localparam logic [PWM_W-1:0] DUTY_LO   = PWM_W'(PWM_MIN);

  typedef enum logic [2:0] {
    STOP         = 3'd0,
    FILLING      = 3'd1,
    DRAINING_MIN = 3'd2,
    DRAINING_MAX = 3'd3,
    STOPPING     = 3'd4,
    FAULT        = 3'd5
  } state_t;

  state_t           state, nxt;
  logic             refill_inc;
  logic [FTW-1:0]   fill_tmr;
  logic [MTW-1:0]   min_tmr;
  logic [WTW-1:0]   wd_tmr;
  logic [RDW-1:0]   tick_cnt;
  logic [PWM_W-1:0] tgt_a, tgt_b;

  wire critical = |status_data;
  wire in_drain = (state == DRAINING_MIN) || (state == DRAINING_MAX) ||
                  (state == STOPPING);
  wire wd_run   = in_drain && !is_empty;
  wire wd_hit   = wd_run && (wd_tmr >= WD_LAST);
  wire fill_done = (fill_tmr >= FILL_LAST);
  wire min_done  = (min_tmr >= MIN_LAST);
  wire ref_full  = (refill_count == REF_LIMIT);
  wire tick      = (tick_cnt == '0);

  // Step a duty toward its target by RAMP_STEP without overshooting.
  function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    int c, t;
    c = int'(cur);
    t = int'(tgt);
    if (c < t)      c = ((t - c) > RAMP_STEP) ? c + RAMP_STEP : t;
    else if (c > t) c = ((c - t) > RAMP_STEP) ? c - RAMP_STEP : t;
    return PWM_W'(c);
  endfunction

  // Next-state decision in per-state priority order.
  always_comb begin
    nxt        = state;
    refill_inc = 1'b0;
    case (state)
      STOP:     if (enable && critical) nxt = FILLING;
      FILLING: begin
        if (!enable)        nxt = STOPPING;
        else if (fill_done) nxt = DRAINING_MIN;
      end
      DRAINING_MIN, DRAINING_MAX: begin
        if (wd_hit)                    nxt = FAULT;
        else if (!enable || !critical) nxt = STOPPING;
        else if (is_empty) begin
          if (ref_full) nxt = FAULT;
          else begin
            nxt        = FILLING;
            refill_inc = 1'b1;
          end
        end
        else if ((state == DRAINING_MIN) && min_done) nxt = DRAINING_MAX;
      end
      STOPPING: begin
        if (wd_hit)        nxt = FAULT;
        else if (is_empty) nxt = STOP;
      end
      FAULT:    if (fault_clear) nxt = STOP;
      default:  nxt = STOP;
    endcase
  end

  // State register with registered fault flag and refill counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= STOP;
      fault        <= 1'b0;
      refill_count <= '0;
    end else begin
      state <= nxt;
      fault <= (nxt == FAULT);
      if (nxt == STOP)     refill_count <= '0;
      else if (refill_inc) refill_count <= refill_count + 1'b1;
    end
  end

  assign state_o = state;

  // Dwell timers and drain watchdog; each saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_tmr <= '0;
      min_tmr  <= '0;
      wd_tmr   <= '0;
    end else begin
      if (state != FILLING)       fill_tmr <= '0;
      else if (fill_tmr != FILL_TOP) fill_tmr <= fill_tmr + 1'b1;
      if (state != DRAINING_MIN)  min_tmr <= '0;
      else if (min_tmr != MIN_TOP)   min_tmr <= min_tmr + 1'b1;
      if (!wd_run)                wd_tmr <= '0;
      else if (wd_tmr != WD_TOP)     wd_tmr <= wd_tmr + 1'b1;
    end
  end

  // Free-running ramp tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    tick_cnt <= '0;
    else if (tick_cnt == DIV_LAST) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + 1'b1;
  end

  // Duty targets decoded from the current state.
  always_comb begin
    tgt_a = '0;
    tgt_b = '0;
    case (state)
      FILLING:                tgt_a = DUTY_HI;
      DRAINING_MIN:           tgt_b = DUTY_LO;
      DRAINING_MAX, STOPPING: tgt_b = DUTY_HI;
      default: ;
    endcase
  end

  // Duty registers: FAULT zeroes them immediately, otherwise ramp on ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_duty_a <= '0;
      pwm_duty_b <= '0;
    end else if (state == FAULT) begin
      pwm_duty_a <= '0;
      pwm_duty_b <= '0;
    end else if (RAMP_STEP == 0) begin
      pwm_duty_a <= tgt_a;
      pwm_duty_b <= tgt_b;
    end else if (tick) begin
      pwm_duty_a <= ramp_toward(pwm_duty_a, tgt_a);
      pwm_duty_b <= ramp_toward(pwm_duty_b, tgt_b);
    end
  end

endmodule

// File: tb/tb_filter_ctrl_fsm.sv
// Bench for filter_ctrl_fsm: two instances (no ramp / fast ramp with a longer
// fill) share stimulus and are compared every cycle against a reference model
// plus directed checks on the scenario milestones.
module tb_filter_ctrl_fsm;

  localparam int FILL0 = 10;
  localparam int FILL1 = 40;
  localparam int MINC  = 5;
  localparam int TMO   = 40;
  localparam int MAXR  = 2;
  localparam int RDIV  = 2;
  localparam int STEP1 = 16;
  localparam int PMAX  = 230;
  localparam int PMIN  = 77;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] status_data = 4'd0;
  logic       is_empty = 1'b0;
  logic       fault_clear = 1'b0;

  logic [7:0] duty_a0, duty_b0, duty_a1, duty_b1;
  logic [2:0] state0, state1;
  logic       fault0, fault1;
  logic [1:0] rc0, rc1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  filter_ctrl_fsm #(
    .STATUS_W(4), .PWM_W(8), .PWM_MAX(PMAX), .PWM_MIN(PMIN),
    .FILL_CYCLES(64'(FILL0)), .MIN_CYCLES(64'(MINC)),
    .DRAIN_TIMEOUT_CYCLES(64'(TMO)), .MAX_REFILLS(MAXR),
    .RAMP_STEP(0), .RAMP_DIV(RDIV)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .status_data(status_data),
    .is_empty(is_empty), .fault_clear(fault_clear),
    .pwm_duty_a(duty_a0), .pwm_duty_b(duty_b0), .state_o(state0),
    .fault(fault0), .refill_count(rc0)
  );

  filter_ctrl_fsm #(
    .STATUS_W(4), .PWM_W(8), .PWM_MAX(PMAX), .PWM_MIN(PMIN),
    .FILL_CYCLES(64'(FILL1)), .MIN_CYCLES(64'(MINC)),
    .DRAIN_TIMEOUT_CYCLES(64'(TMO)), .MAX_REFILLS(MAXR),
    .RAMP_STEP(STEP1), .RAMP_DIV(RDIV)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .status_data(status_data),
    .is_empty(is_empty), .fault_clear(fault_clear),
    .pwm_duty_a(duty_a1), .pwm_duty_b(duty_b1), .state_o(state1),
    .fault(fault1), .refill_count(rc1)
  );

  // Reference model: s = state, t = cycles already spent in s, dry = drain
  // cycles since the tank was last seen empty, rc = refills, cnt = ramp phase.
  typedef struct packed {
    int s; int t; int dry; int rc; int cnt; int a; int b;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  function automatic int approach(int cur, int tgt, int step);
    int d;
    d = tgt - cur;
    if (step == 0) return tgt;
    if (d > step) d = step;
    else if (d < -step) d = -step;
    return cur + d;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int fill, int step, logic en,
                                    logic [3:0] st, logic emp, logic clr);
    mdl_t r;
    int nx, dry, ta, tb;
    bit crit, drain;
    r = m;
    crit  = (st != 4'd0);
    drain = (m.s == 2) || (m.s == 3) || (m.s == 4);
    dry   = (drain && !emp) ? m.dry + 1 : 0;
    nx    = m.s;
    case (m.s)
      0: if (en && crit) nx = 1;
      1: if (!en) nx = 4; else if (m.t + 1 >= fill) nx = 2;
      2, 3: begin
        if (dry >= TMO) nx = 5;
        else if (!en || !crit) nx = 4;
        else if (emp) begin
          if (m.rc == MAXR) nx = 5;
          else begin nx = 1; r.rc = m.rc + 1; end
        end
        else if (m.s == 2 && m.t + 1 >= MINC) nx = 3;
      end
      4: if (dry >= TMO) nx = 5; else if (emp) nx = 0;
      5: if (clr) nx = 0;
      default: nx = 0;
    endcase
    if (nx == 0) r.rc = 0;
    ta = (m.s == 1) ? PMAX : 0;
    tb = (m.s == 2) ? PMIN : ((m.s == 3 || m.s == 4) ? PMAX : 0);
    if (m.s == 5) begin
      r.a = 0; r.b = 0;
    end else if (step == 0 || m.cnt == 0) begin
      r.a = approach(m.a, ta, step);
      r.b = approach(m.b, tb, step);
    end
    r.cnt = (m.cnt + 1) % RDIV;
    r.t   = (nx == m.s) ? m.t + 1 : 0;
    r.dry = dry;
    r.s   = nx;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("s0_state", 32'(state0), 32'(m0.s));
    chk("s0_fault", 32'(fault0), 32'(m0.s == 5));
    chk("s0_refill", 32'(rc0), 32'(m0.rc));
    chk("s0_duty_a", 32'(duty_a0), 32'(m0.a));
    chk("s0_duty_b", 32'(duty_b0), 32'(m0.b));
    chk("s1_state", 32'(state1), 32'(m1.s));
    chk("s1_fault", 32'(fault1), 32'(m1.s == 5));
    chk("s1_refill", 32'(rc1), 32'(m1.rc));
    chk("s1_duty_a", 32'(duty_a1), 32'(m1.a));
    chk("s1_duty_b", 32'(duty_b1), 32'(m1.b));
  endtask

  // One clock: drive inputs, advance the model, check #1 after the edge.
  task automatic cyc(input logic e, input logic [3:0] st, input logic em, input logic cl);
    enable = e; status_data = st; is_empty = em; fault_clear = cl;
    m0 = mdl_step(m0, FILL0, 0, e, st, em, cl);
    m1 = mdl_step(m1, FILL1, STEP1, e, st, em, cl);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic run(input int n, input logic e, input logic [3:0] st, input logic em);
    for (int i = 0; i < n; i++) cyc(e, st, em, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic reset_dut();
    reset = 1'b1;
    #2;
    m0 = mdl_reset();
    m1 = mdl_reset();
    chk("rst_async_state", 32'(state0), 32'd0);
    chk("rst_async_duty", 32'({duty_a0, duty_b0}), 32'd0);
    chk("rst_async_refill", 32'(rc0), 32'd0);
    check_all();
    @(posedge clk); #1;
    check_all();
    reset = 1'b0;
    enable = 1'b0; status_data = 4'd0; is_empty = 1'b0; fault_clear = 1'b0;
  endtask

  initial begin
    m0 = mdl_reset();
    m1 = mdl_reset();
    @(posedge clk); #1;
    reset_dut();
    chk("reset_fault", 32'(fault0), 32'd0);

    // Nominal run.
    run(11, 1'b1, 4'b0010, 1'b0);
    chk("nom_dmin", 32'(state0), 32'd2);
    chk("nom_fill_duty_a", 32'(duty_a0), 32'd230);
    run(1, 1'b1, 4'b0010, 1'b0);
    chk("nom_dmin_duty_b", 32'(duty_b0), 32'd77);
    run(4, 1'b1, 4'b0010, 1'b0);
    chk("nom_dmax", 32'(state0), 32'd3);
    run(3, 1'b1, 4'b0010, 1'b0);
    chk("nom_dmax_duty_b", 32'(duty_b0), 32'd230);
    run(2, 1'b1, 4'b0000, 1'b0);
    chk("nom_stopping", 32'(state0), 32'd4);
    run(1, 1'b1, 4'b0000, 1'b1);
    chk("nom_stop", 32'(state0), 32'd0);
    run(2, 1'b0, 4'b0000, 1'b0);

    // Refill limit.
    reset_dut();
    run(11, 1'b1, 4'b0100, 1'b0);
    run(1, 1'b1, 4'b0100, 1'b1);
    chk("ref1_state", 32'(state0), 32'd1);
    chk("ref1_count", 32'(rc0), 32'd1);
    run(10, 1'b1, 4'b0100, 1'b0);
    run(5, 1'b1, 4'b0100, 1'b0);
    chk("ref_dmax", 32'(state0), 32'd3);
    run(1, 1'b1, 4'b0100, 1'b1);
    chk("ref2_count", 32'(rc0), 32'd2);
    run(10, 1'b1, 4'b0100, 1'b0);
    run(1, 1'b1, 4'b0100, 1'b1);
    chk("ref3_fault", 32'(fault0), 32'd1);
    chk("ref3_hold", 32'(rc0), 32'd2);
    run(1, 1'b1, 4'b0100, 1'b1);
    chk("ref3_duties", 32'({duty_a0, duty_b0}), 32'd0);
    cyc(1'b1, 4'b0100, 1'b0, 1'b1);
    chk("clr_stop", 32'(state0), 32'd0);
    chk("clr_refill", 32'(rc0), 32'd0);

    // Watchdog in STOPPING.
    reset_dut();
    run(3, 1'b1, 4'b0001, 1'b0);
    run(1, 1'b0, 4'b0001, 1'b0);
    chk("wd_stopping", 32'(state0), 32'd4);
    run(39, 1'b0, 4'b0001, 1'b0);
    chk("wd_39", 32'(state0), 32'd4);
    run(1, 1'b0, 4'b0001, 1'b0);
    chk("wd_40_fault", 32'(state0), 32'd5);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    reset_dut();
    run(3, 1'b1, 4'b0001, 1'b0);
    run(1, 1'b0, 4'b0001, 1'b0);
    run(29, 1'b0, 4'b0001, 1'b0);
    run(1, 1'b0, 4'b0001, 1'b1);
    chk("wd_pulse_stop", 32'(state0), 32'd0);
    run(15, 1'b0, 4'b0001, 1'b0);
    chk("wd_pulse_nofault", 32'(fault0), 32'd0);

    // Enable drop mid-fill.
    reset_dut();
    run(5, 1'b1, 4'b1000, 1'b0);
    run(1, 1'b0, 4'b1000, 1'b0);
    chk("endrop_stopping", 32'(state0), 32'd4);
    run(1, 1'b0, 4'b1000, 1'b0);
    chk("endrop_duty_a", 32'(duty_a0), 32'd0);
    chk("endrop_duty_b", 32'(duty_b0), 32'd230);

    // is_empty on the final DRAINING_MIN cycle takes the refill.
    reset_dut();
    run(15, 1'b1, 4'b0010, 1'b0);
    run(1, 1'b1, 4'b0010, 1'b1);
    chk("coinc_refill", 32'(state0), 32'd1);

    // Long ramp run; then reset in DRAINING_MAX.
    reset_dut();
    run(45, 1'b1, 4'b0011, 1'b0);
    reset_dut();
    run(17, 1'b1, 4'b0011, 1'b0);
    chk("pre_reset_dmax", 32'(state0), 32'd3);
    reset_dut();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic e, em, cl;
      logic [3:0] st;
      if ($urandom_range(0, 799) == 0) reset_dut();
      else begin
        e  = ($urandom_range(0, 19) != 0);
        st = ($urandom_range(0, 9) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        em = ($urandom_range(0, 24) == 0);
        cl = ($urandom_range(0, 7) == 0);
        cyc(e, st, em, cl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
